// File: rtl/codec_pkg.sv
// -----------------------------------------------------------------------------
// codec_pkg
// Shared definitions for the WM8731 codec initialisation sequencer:
//   - state_e          : sequencer FSM states
//   - CODEC_DEV_BYTE   : I2C device byte (7-bit address 7'h1A, write bit 0)
//   - CMD_W            : width of one I2C command word (device byte + 16 bits)
//   - codec_cmd(idx)   : 16-bit register word for table entry idx
// -----------------------------------------------------------------------------
package codec_pkg;

   localparam int unsigned CMD_W          = 24;
   localparam logic [7:0]  CODEC_DEV_BYTE = 8'h34;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_LOW,
      WAIT_HIGH,
      GAP,
      DONE,
      ERROR
   } state_e;

   // Register words in issue order: reset first, then line inputs,
   // headphone volumes, analog/digital paths, power, format, sampling, active.
   function automatic logic [15:0] codec_cmd(input logic [3:0] idx);
      logic [15:0] word;
      case (idx)
         4'd0:    word = 16'h1E00;
         4'd1:    word = 16'h0097;
         4'd2:    word = 16'h0297;
         4'd3:    word = 16'h0479;
         4'd4:    word = 16'h0679;
         4'd5:    word = 16'h0815;
         4'd6:    word = 16'h0A00;
         4'd7:    word = 16'h0C00;
         4'd8:    word = 16'h0E42;
         4'd9:    word = 16'h1019;
         4'd10:   word = 16'h1201;
         default: word = 16'h0000;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/codec_cmd_rom.sv
// -----------------------------------------------------------------------------
// codec_cmd_rom
// Combinational command table: maps a 4-bit command index to the 24-bit I2C
// write word {device byte, register word}. Indices at or beyond NUM_CMD
// return all zeros.
//   idx_i : command index
//   cmd_o : 24-bit command word
// -----------------------------------------------------------------------------
module codec_cmd_rom
   import codec_pkg::*;
#(
   parameter int unsigned NUM_CMD = 11
)(
   input  logic [3:0]       idx_i,
   output logic [CMD_W-1:0] cmd_o
);

   localparam logic [4:0] NUM_CMD_W = 5'(NUM_CMD);

   always_comb begin
      // NOTE: default assignment first so every path drives cmd_o and no latch is inferred.
      cmd_o = '0;
      if ({1'b0, idx_i} < NUM_CMD_W) begin
         cmd_o = {CODEC_DEV_BYTE, codec_cmd(idx_i)};
      end
   end

endmodule

// File: rtl/i2c_codec_init_seq.sv
// -----------------------------------------------------------------------------
// i2c_codec_init_seq
// Walks the codec command table and hands each 24-bit word to the I2C sender,
// handshaking on start/finished, retrying starts the sender does not take,
// and leaving an idle gap between commands.
//   i_clk          : system clock
//   i_rst          : synchronous reset, active high
//   i_go           : begin a full run from entry 0 (sampled in IDLE/DONE/ERROR)
//   o_i2c_start    : one-cycle start pulse to the sender
//   o_i2c_dat      : command word, stable from start until finished rises
//   i_i2c_finished : sender status, 1 = idle, 0 = transferring
//   o_busy         : run in progress
//   o_done         : sticky, all commands completed
//   o_error        : sticky, a command ran out of retries
//   o_cmd_idx      : index of the current or last command
// -----------------------------------------------------------------------------
module i2c_codec_init_seq
   import codec_pkg::*;
#(
   parameter int unsigned NUM_CMD     = 11,
   parameter int unsigned GAP_CYCLES  = 8,
   parameter int unsigned ACK_TIMEOUT = 4,
   parameter int unsigned MAX_RETRY   = 3
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_go,
   output logic             o_i2c_start,
   output logic [CMD_W-1:0] o_i2c_dat,
   input  logic             i_i2c_finished,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [3:0]       o_cmd_idx
);

   localparam logic [3:0] LAST_IDX  = 4'(NUM_CMD - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);
   localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

   state_e           state_q;
   logic             start_q;
   logic [CMD_W-1:0] dat_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [3:0]       idx_q;
   logic [7:0]       gap_q;
   logic [7:0]       tmo_q;
   logic [7:0]       retry_q;
   logic [CMD_W-1:0] rom_word_d;

   codec_cmd_rom #(
      .NUM_CMD (NUM_CMD)
   ) u_rom (
      .idx_i (idx_q),
      .cmd_o (rom_word_d)
   );

   // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         dat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         idx_q   <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         retry_q <= '0;
      end else begin
         // Start is a pulse: raised only on the edge that enters START.
         start_q <= 1'b0;
         case (state_q)
            IDLE, DONE, ERROR: begin
               if (i_go) begin
                  idx_q   <= '0;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  retry_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               dat_q   <= rom_word_d;
               start_q <= 1'b1;
               state_q <= START;
            end
            START: begin
               tmo_q   <= '0;
               state_q <= WAIT_LOW;
            end
            WAIT_LOW: begin
               // tmo_q + 1 is the number of cycles since the start pulse; giving
               // up one cycle early lands the reissued start exactly
               // ACK_TIMEOUT cycles after the previous one (ACK_TIMEOUT >= 2).
               if (!i_i2c_finished) begin
                  state_q <= WAIT_HIGH;
               end else if ((tmo_q + 8'd1) == TMO_LAST) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_q <= retry_q + 8'd1;
                     start_q <= 1'b1;
                     state_q <= START;
                  end else begin
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                     state_q <= ERROR;
                  end
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            WAIT_HIGH: begin
               if (i_i2c_finished) begin
                  gap_q   <= GAP_LOAD;
                  retry_q <= '0;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  if (idx_q == LAST_IDX) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     state_q <= LOAD;
                  end
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_i2c_start = start_q;
   assign o_i2c_dat   = dat_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_error     = error_q;
   assign o_cmd_idx   = idx_q;

endmodule

// File: tb/tb_i2c_codec_init_seq.sv
// -----------------------------------------------------------------------------
// tb_i2c_codec_init_seq
// Self-checking bench. A sender model answers start pulses (optionally
// ignoring some) and a timeline model predicts, per cycle, every DUT output
// from the handshake timing rules. A negedge process compares them.
// -----------------------------------------------------------------------------
module tb_i2c_codec_init_seq;

   localparam int NUM_CMD = 11;
   localparam int GAP     = 8;
   localparam int ACK     = 4;
   localparam int RETRY   = 3;
   localparam int WIN     = 1024;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_go  = 1'b0;
   logic        i_i2c_finished = 1'b1;
   logic        o_i2c_start;
   logic [23:0] o_i2c_dat;
   logic        o_busy;
   logic        o_done;
   logic        o_error;
   logic [3:0]  o_cmd_idx;

   i2c_codec_init_seq #(
      .NUM_CMD     (NUM_CMD),
      .GAP_CYCLES  (GAP),
      .ACK_TIMEOUT (ACK),
      .MAX_RETRY   (RETRY)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_go           (i_go),
      .o_i2c_start    (o_i2c_start),
      .o_i2c_dat      (o_i2c_dat),
      .i_i2c_finished (i_i2c_finished),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_error        (o_error),
      .o_cmd_idx      (o_cmd_idx)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [23:0] spec_word(input int k);
      logic [15:0] w;
      case (k)
         0:       w = 16'h1E00;
         1:       w = 16'h0097;
         2:       w = 16'h0297;
         3:       w = 16'h0479;
         4:       w = 16'h0679;
         5:       w = 16'h0815;
         6:       w = 16'h0A00;
         7:       w = 16'h0C00;
         8:       w = 16'h0E42;
         9:       w = 16'h1019;
         10:      w = 16'h1201;
         default: w = 16'h0000;
      endcase
      return {8'h34, w};
   endfunction

   // ---------------- run configuration and timeline model ----------------
   int          xf [16];     // transfer length (cycles finished stays low)
   int          ig [16];     // starts the sender ignores for this command
   int          sa_off [16]; // offset of the accepted start per command
   bit          in_run = 1'b0;
   int          g = 0;       // absolute cycle of the first LOAD
   int          term = 0;    // offset at which DONE/ERROR becomes visible
   bit          e_start [WIN];
   logic [23:0] e_dat   [WIN];
   logic [3:0]  e_idx   [WIN];
   logic [23:0] rest_dat = '0, pre_dat = '0, fin_dat = '0;
   logic [3:0]  rest_idx = '0, pre_idx = '0, fin_idx = '0;
   bit          rest_done = 1'b0, pre_done = 1'b0, fin_done = 1'b0;
   bit          rest_err  = 1'b0, pre_err  = 1'b0, fin_err  = 1'b0;
   bit          acc_q [$];
   int          xf_q  [$];
   int          st_cyc [$];
   logic [23:0] st_dat [$];

   // Event timeline of one run, offsets relative to the first LOAD cycle:
   // starts 1 cycle after LOAD, ignored starts repeat every ACK cycles, an
   // accepted start at sa leads to the next LOAD at sa + xfer + GAP + 2.
   function automatic void build(input int gg);
      int t, s, sa, nt;
      pre_dat  = in_run ? fin_dat  : rest_dat;
      pre_idx  = in_run ? fin_idx  : rest_idx;
      pre_done = in_run ? fin_done : rest_done;
      pre_err  = in_run ? fin_err  : rest_err;
      for (int i = 0; i < WIN; i++) begin
         e_start[i] = 1'b0;
         e_dat[i]   = pre_dat;
         e_idx[i]   = '0;
      end
      acc_q.delete();
      xf_q.delete();
      t    = 0;
      term = 0;
      for (int k = 0; k < NUM_CMD; k++) begin
         s = t + 1;
         if (ig[k] > RETRY) begin
            for (int j = 0; j <= RETRY; j++) begin
               e_start[s + j * ACK] = 1'b1;
               acc_q.push_back(1'b0);
            end
            term = s + (RETRY + 1) * ACK;
            for (int i = t; i < term; i++) e_idx[i] = 4'(k);
            for (int i = t + 1; i < term; i++) e_dat[i] = spec_word(k);
            fin_done = 1'b0;
            fin_err  = 1'b1;
            fin_idx  = 4'(k);
            fin_dat  = spec_word(k);
            break;
         end
         for (int j = 0; j <= ig[k]; j++) begin
            e_start[s + j * ACK] = 1'b1;
            acc_q.push_back(j == ig[k]);
         end
         xf_q.push_back(xf[k]);
         sa        = s + ig[k] * ACK;
         sa_off[k] = sa;
         nt        = sa + xf[k] + GAP + 2;
         for (int i = t; i < nt; i++) e_idx[i] = 4'(k);
         for (int i = t + 1; i <= nt; i++) e_dat[i] = spec_word(k);
         if (k == NUM_CMD - 1) begin
            term     = nt;
            fin_done = 1'b1;
            fin_err  = 1'b0;
            fin_idx  = 4'(k);
            fin_dat  = spec_word(k);
         end else begin
            t = nt;
         end
      end
      g      = gg;
      in_run = 1'b1;
   endfunction

   function automatic void model_reset();
      in_run    = 1'b0;
      rest_dat  = '0;
      rest_idx  = '0;
      rest_done = 1'b0;
      rest_err  = 1'b0;
      acc_q.delete();
      xf_q.delete();
   endfunction

   // ---------------- sender model ----------------
   int rem = 0;
   always @(posedge i_clk) begin : sender
      bit acc;
      #1;
      if (i_rst) begin
         rem            = 0;
         i_i2c_finished = 1'b1;
      end else begin
         if (rem > 0) begin
            i_i2c_finished = 1'b0;
            rem--;
         end else begin
            i_i2c_finished = 1'b1;
         end
         if (o_i2c_start) begin
            acc = (acc_q.size() > 0) ? acc_q.pop_front() : 1'b1;
            if (acc) rem = (xf_q.size() > 0) ? xf_q.pop_front() : 5;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge i_clk) begin : cmp
      bit          x_s, x_b, x_d, x_e;
      logic [3:0]  x_i;
      logic [23:0] x_w;
      int          off;
      if (chk_en) begin
         if (!in_run) begin
            x_s = 1'b0; x_b = 1'b0; x_d = rest_done; x_e = rest_err; x_i = rest_idx; x_w = rest_dat;
         end else begin
            off = cyc - g;
            if (off < 0) begin
               x_s = 1'b0; x_b = 1'b0; x_d = pre_done; x_e = pre_err; x_i = pre_idx; x_w = pre_dat;
            end else if (off < term) begin
               x_s = e_start[off]; x_b = 1'b1; x_d = 1'b0; x_e = 1'b0; x_i = e_idx[off]; x_w = e_dat[off];
            end else begin
               x_s = 1'b0; x_b = 1'b0; x_d = fin_done; x_e = fin_err; x_i = fin_idx; x_w = fin_dat;
            end
         end
         check("start", 32'(o_i2c_start), 32'(x_s));
         check("dat",   32'(o_i2c_dat),   32'(x_w));
         check("busy",  32'(o_busy),      32'(x_b));
         check("done",  32'(o_done),      32'(x_d));
         check("error", 32'(o_error),     32'(x_e));
         check("idx",   32'(o_cmd_idx),   32'(x_i));
         if (o_i2c_start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(o_i2c_dat);
         end
         if (bad >= 40) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic start_run(input bit hold);
      st_cyc.delete();
      st_dat.delete();
      i_go = 1'b1;
      build(cyc + 1);
      tick();
      if (!hold) i_go = 1'b0;
   endtask

   task automatic wait_end();
      while (cyc < g + term) tick();
   endtask

   task automatic cfg_fixed(input int x);
      for (int k = 0; k < 16; k++) begin
         xf[k] = x;
         ig[k] = 0;
      end
   endtask

   task automatic cfg_random();
      for (int k = 0; k < 16; k++) begin
         xf[k] = int'($urandom_range(1, 40));
         ig[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      if ($urandom_range(0, 3) == 0) ig[$urandom_range(0, NUM_CMD - 1)] = RETRY + 1;
   endtask

   initial begin
      cfg_fixed(30);
      repeat (3) tick();
      i_rst  = 1'b0;
      chk_en = 1'b1;
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_dat",  32'(o_i2c_dat), 32'd0);
      check("reset_idx",  32'(o_cmd_idx), 32'd0);
      repeat (5) tick();

      // Full run, sender answers every start after 1 cycle, 30-cycle transfers.
      cfg_fixed(30);
      start_run(1'b0);
      wait_end();
      check("runA_starts", 32'(st_dat.size()), 32'd11);
      if (st_dat.size() >= 11) begin
         check("runA_first_dat", 32'(st_dat[0]), 32'h341E00);
         check("runA_second_dat", 32'(st_dat[1]), 32'h340097);
         check("runA_last_dat", 32'(st_dat[10]), 32'h341201);
         check("runA_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd41);
      end
      check("runA_done", 32'(o_done), 32'd1);
      check("runA_busy", 32'(o_busy), 32'd0);
      check("runA_idx",  32'(o_cmd_idx), 32'd10);
      repeat (4) tick();

      // Command 2 is never accepted: three reissues, then error.
      cfg_fixed(30);
      ig[2] = RETRY + 1;
      start_run(1'b0);
      wait_end();
      check("runB_starts", 32'(st_dat.size()), 32'd6);
      if (st_dat.size() >= 6) begin
         check("runB_retry_gap1", 32'(st_cyc[3] - st_cyc[2]), 32'd4);
         check("runB_retry_gap3", 32'(st_cyc[5] - st_cyc[4]), 32'd4);
         check("runB_retry_dat",  32'(st_dat[5]), 32'h340297);
      end
      check("runB_error", 32'(o_error), 32'd1);
      check("runB_idx",   32'(o_cmd_idx), 32'd2);
      repeat (20) tick();
      check("runB_no_more_starts", 32'(st_dat.size()), 32'd6);

      // Only the first start of command 4 is ignored.
      cfg_fixed(30);
      ig[4] = 1;
      start_run(1'b0);
      wait_end();
      check("runC_starts", 32'(st_dat.size()), 32'd12);
      check("runC_done",   32'(o_done), 32'd1);
      check("runC_error",  32'(o_error), 32'd0);

      // i_go held through a run: no mid-run restart, restart right after DONE.
      cfg_random();
      for (int k = 0; k < 16; k++) ig[k] = 0;
      start_run(1'b1);
      wait_end();
      check("hold_done_seen", 32'(o_done), 32'd1);
      tick();
      build(cyc);
      i_go = 1'b0;
      st_cyc.delete();
      st_dat.delete();
      check("hold_restart_busy", 32'(o_busy), 32'd1);
      check("hold_restart_done", 32'(o_done), 32'd0);
      check("hold_restart_idx",  32'(o_cmd_idx), 32'd0);
      wait_end();
      repeat (3) tick();

      // Reset during WAIT_HIGH of command 5.
      cfg_fixed(30);
      start_run(1'b0);
      while (cyc < g + sa_off[5] + 3) tick();
      i_rst = 1'b1;
      tick();
      model_reset();
      i_rst = 1'b0;
      check("midrst_busy",  32'(o_busy), 32'd0);
      check("midrst_start", 32'(o_i2c_start), 32'd0);
      check("midrst_dat",   32'(o_i2c_dat), 32'd0);
      check("midrst_idx",   32'(o_cmd_idx), 32'd0);
      repeat (6) tick();
      cfg_random();
      start_run(1'b0);
      wait_end();
      if (st_dat.size() >= 1) check("midrst_restart_dat", 32'(st_dat[0]), 32'h341E00);
      else check("midrst_restart_starts", 32'(st_dat.size()), 32'd1);

      // Randomised runs.
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 10)) tick();
         cfg_random();
         start_run(1'b0);
         wait_end();
      end
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_codec_init_seq.md
Name: i2c_codec_init_seq

Overview:
- Sequencer that configures the WM8731 audio codec after power-up or on demand.
- Walks a fixed table of 24-bit I2C write commands (device byte + 16-bit register word) and issues each one to the I2C sender, which is instantiated with BYTE=3.
- Handshakes on the sender's start/finished pair and inserts an idle gap between commands.
- Sits between top-level reset/control logic and the I2C sender; reports busy/done to the top level.

Parameters:
- NUM_CMD, 11, number of table entries issued per run (max 16).
- GAP_CYCLES, 8, idle i_clk cycles between a finished command and the next start (min 1).
- ACK_TIMEOUT, 4, cycles allowed for sender finished to drop after a start pulse before the start is reissued.
- MAX_RETRY, 3, reissues per command before the error state is taken.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_go  in  1  level/pulse; sampled in IDLE or DONE/ERROR to begin a full run from entry 0.
- o_i2c_start  out  1  one-cycle start pulse to the sender.
- o_i2c_dat  out  24  command word to the sender; held stable from the start pulse until finished rises.
- i_i2c_finished  in  1  sender status: 1 = idle, 0 = transferring.
- o_busy  out  1  high while a run is in progress.
- o_done  out  1  sticky high after all NUM_CMD commands complete; cleared on a new run or reset.
- o_error  out  1  sticky high if a command exhausts MAX_RETRY; cleared on a new run or reset.
- o_cmd_idx  out  4  index of the current or last command.

Behaviour:
- Reset state, on the i_rst edge: state=IDLE; o_i2c_start=0, o_i2c_dat=0, o_busy=0, o_done=0, o_error=0, o_cmd_idx=0; gap and retry counters = 0.
- Reset mid-run aborts the run immediately with no completion of the current command. The sender is reset by the same system reset.
- Table: bits [23:16] = 8'h34 (address 7'h1A, write). Bits [15:0] by index:
  - 0: 16'h1E00 (codec reset)
  - 1–5: 16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0815
  - 6–10: 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201
- FSM states: IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, GAP, DONE, ERROR.
- IDLE/DONE/ERROR → LOAD when i_go=1. Entering LOAD from any of these sets o_cmd_idx=0, clears o_done/o_error/retry, and sets o_busy=1.
- LOAD: latch the table entry for o_cmd_idx onto o_i2c_dat → START.
- START: o_i2c_start=1 for exactly one cycle; clear the timeout counter → WAIT_LOW.
- WAIT_LOW:
  - i_i2c_finished=0 → WAIT_HIGH.
  - Otherwise count. When the count reaches ACK_TIMEOUT: if retry<MAX_RETRY, increment retry → START; else → ERROR.
- WAIT_HIGH: i_i2c_finished=1 → GAP with the gap counter loaded to GAP_CYCLES-1 and retry cleared. No timeout in this state.
- GAP: count down to 0.
  - If o_cmd_idx==NUM_CMD-1 → DONE.
  - Else increment o_cmd_idx → LOAD.
- DONE: o_busy=0, o_done=1. ERROR: o_busy=0, o_error=1, o_cmd_idx holds the failing index.
- i_go while busy is ignored; no queueing.
- i_i2c_finished already 0 when a run starts: START is still issued; the WAIT_LOW→WAIT_HIGH path handles it.
- Latency per command, with finished dropping 1 cycle after start: 1 (LOAD) + 1 (START) + ≥1 (WAIT_LOW) + transfer + GAP_CYCLES.
- o_i2c_start is never asserted in any state other than START.

Decomposition:
- Shared package codec_pkg:
  - FSM state enum.
  - Constants CODEC_DEV_BYTE=8'h34 and CMD_W=24.
  - Function codec_cmd(idx) returning the 16-bit register word.
- Sub-module codec_cmd_rom: combinational 4-bit index → 24-bit word. Indices ≥ NUM_CMD return 24'h000000.

Test Plan:
- Reset then i_go pulse; sender model drops finished 1 cycle after start and raises it 30 cycles later → 11 start pulses with o_i2c_dat = 24'h341E00, 24'h340097 … 24'h341201 in order; ≥8 idle cycles between each; o_done=1, o_busy=0, o_cmd_idx=10.
- Sender model ignores start for command 2 → start reissued 3 times, 4 cycles apart; then o_error=1, o_cmd_idx=2, no further starts.
- Sender ignores only the first start of command 4 → one retry, then the run completes with o_done=1 and o_error=0.
- i_go held high throughout a run → no restart mid-run. After DONE, a fresh run begins from index 0 and o_done clears on the LOAD cycle.
- i_rst asserted during WAIT_HIGH of command 5 → next cycle all outputs are at reset values and state is IDLE; a later i_go restarts from 24'h341E00.
- Check o_i2c_dat stability: it never changes between a start pulse and the following finished rise, across a full run.
